// File: rtl/input_feed_ctrl_pkg.sv
// Shared helpers for the systolic-array input feed controller.
// Defaults normally come from the shared config.v; fall back if it was not included.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif
`ifndef DSP_DELAY
`define DSP_DELAY 4
`endif

package input_feed_ctrl_pkg;

    // Cycles needed to push one tile through the skewed PE array.
    function automatic int drain_len(input int array_width, input int dsp_delay);
        return (dsp_delay - 1) * (array_width - 1) + array_width;
    endfunction

endpackage

// File: rtl/input_feed_ctrl.sv
// Input feed controller: collects ARRAYWIDTH beats per tile, drains the row
// shifters for the skewed array depth, then reloads their skew counters.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif
`ifndef DSP_DELAY
`define DSP_DELAY 4
`endif

module input_feed_ctrl
    import input_feed_ctrl_pkg::*;
#(
    parameter int ARRAYWIDTH = `ARRAYWIDTH,
    parameter int DATASIZE   = `DATASIZE,
    parameter int DSP_DELAY  = `DSP_DELAY
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [ARRAYWIDTH*DATASIZE-1:0]   s_data,
    input  logic                             flush,
    output logic                             load_en,
    output logic [ARRAYWIDTH*DATASIZE-1:0]   load_data,
    output logic                             out_en,
    output logic                             delay_clear,
    output logic                             tile_done,
    output logic                             busy
);

    localparam int DRAIN_LEN = drain_len(ARRAYWIDTH, DSP_DELAY);
    localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);
    localparam int BEAT_W    = $clog2(ARRAYWIDTH);
    localparam int W         = ARRAYWIDTH * DATASIZE;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ARRAYWIDTH - 1);
    localparam logic [DCNT_W-1:0] DRAIN_END = DCNT_W'(DRAIN_LEN);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [BEAT_W-1:0]   beat, beat_n;
    logic [DCNT_W-1:0]   dcnt, dcnt_n;
    logic                abort, abort_n;
    logic                load_en_n, out_en_n, delay_clear_n, tile_done_n;
    logic                s_ready_n, busy_n;
    logic [W-1:0]        load_data_n;

    always_comb begin
        state_n       = state;
        beat_n        = beat;
        dcnt_n        = dcnt;
        abort_n       = 1'b0;
        load_en_n     = 1'b0;
        load_data_n   = '0;
        out_en_n      = 1'b0;
        delay_clear_n = 1'b0;
        tile_done_n   = 1'b0;
        unique case (state)
            LOAD: begin
                // A beat arriving together with flush is dropped.
                if (flush) begin
                    state_n = CLEAR;
                    beat_n  = '0;
                    abort_n = 1'b1;
                end else if (s_valid) begin
                    load_en_n   = 1'b1;
                    load_data_n = s_data;
                    if (beat == LAST_BEAT) begin
                        beat_n  = '0;
                        dcnt_n  = '0;
                        state_n = DRAIN;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // First DRAIN cycle still carries the last load strobe, so out_en lags by one.
                if (flush) begin
                    state_n = CLEAR;
                    dcnt_n  = '0;
                    abort_n = 1'b1;
                end else if (dcnt == DRAIN_END) begin
                    state_n       = CLEAR;
                    dcnt_n        = '0;
                    delay_clear_n = 1'b1;
                    tile_done_n   = 1'b1;
                end else begin
                    dcnt_n   = dcnt + 1'b1;
                    out_en_n = 1'b1;
                end
            end
            CLEAR: begin
                // An aborted tile spends one extra cycle here to issue its delay_clear.
                if (abort) begin
                    delay_clear_n = 1'b1;
                end else begin
                    state_n = LOAD;
                end
            end
            default: state_n = LOAD;
        endcase
        s_ready_n = (state_n == LOAD);
        busy_n    = !((state_n == LOAD) && (beat_n == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            beat        <= '0;
            dcnt        <= '0;
            abort       <= 1'b0;
            load_en     <= 1'b0;
            load_data   <= '0;
            out_en      <= 1'b0;
            delay_clear <= 1'b0;
            tile_done   <= 1'b0;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            beat        <= beat_n;
            dcnt        <= dcnt_n;
            abort       <= abort_n;
            load_en     <= load_en_n;
            load_data   <= load_data_n;
            out_en      <= out_en_n;
            delay_clear <= delay_clear_n;
            tile_done   <= tile_done_n;
            s_ready     <= s_ready_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_input_feed_ctrl.sv
// Self-checking bench for input_feed_ctrl against a schedule-based reference model.
module tb_input_feed_ctrl;

    localparam int AW = 4;
    localparam int DS = 8;
    localparam int DD = 4;
    localparam int DL = (DD - 1) * (AW - 1) + AW;
    localparam int W  = AW * DS;
    localparam int OW = W + 6;
    localparam int N  = 2048;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_ready, load_en, out_en, delay_clear, tile_done, busy;
    logic [W-1:0] load_data;

    input_feed_ctrl #(.ARRAYWIDTH(AW), .DATASIZE(DS), .DSP_DELAY(DD)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .flush(flush), .load_en(load_en), .load_data(load_data), .out_en(out_en),
        .delay_clear(delay_clear), .tile_done(tile_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int chk_from = -1;

    // Reference model: a schedule of expected output values per cycle.
    int m_ready_from = 0;
    int m_beats = 0;
    int m_clr_lo = -1;
    int m_clr_hi = -2;
    bit           e_load[N], e_out[N], e_dc[N], e_done[N], e_ready[N], e_busy[N];
    logic [W-1:0] e_data[N];
    logic [OW-1:0] obs[N];

    function automatic logic [OW-1:0] expv(input int c);
        return {e_ready[c], e_load[c], e_data[c], e_out[c], e_dc[c], e_done[c], e_busy[c]};
    endfunction

    task automatic wipe(input int c);
        for (int k = c + 1; k <= c + DL + 4 && k < N; k++) begin
            e_load[k] = 0; e_data[k] = '0; e_out[k] = 0; e_dc[k] = 0; e_done[k] = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input logic fl, input logic r);
        int c;
        bit rdy;
        c = cyc;
        rdy = (c >= m_ready_from);
        e_ready[c] = rdy;
        e_busy[c] = !(rdy && m_beats == 0);
        if (r) begin
            wipe(c);
            m_ready_from = c + 1; m_beats = 0; m_clr_lo = -1; m_clr_hi = -2;
            if (chk_from < 0) chk_from = c + 1;
            return;
        end
        if (fl && !(c >= m_clr_lo && c <= m_clr_hi)) begin
            wipe(c);
            e_dc[c + 2] = 1;
            m_ready_from = c + 3; m_beats = 0; m_clr_lo = c + 1; m_clr_hi = c + 2;
            return;
        end
        if (v && rdy) begin
            e_load[c + 1] = 1;
            e_data[c + 1] = d;
            m_beats++;
            if (m_beats == AW) begin
                m_beats = 0;
                for (int k = 2; k <= DL + 1; k++) e_out[c + k] = 1;
                e_dc[c + 2 + DL] = 1;
                e_done[c + 2 + DL] = 1;
                m_ready_from = c + 3 + DL;
                m_clr_lo = c + 2 + DL;
                m_clr_hi = c + 2 + DL;
            end
        end
    endtask

    // One clock cycle: record outputs, advance the model, drive inputs.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic fl, input logic r);
        obs[cyc] = {s_ready, load_en, load_data, out_en, delay_clear, tile_done, busy};
        model_step(v, d, fl, r);
        s_valid = v; s_data = d; flush = fl; rst = r;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [OW-1:0] rst_exp;
        int c0;
        rst_exp = {1'b1, {(OW - 1){1'b0}}};
        c0 = cyc;
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        idle(3);
        checks++;
        if (obs[chk_from] !== rst_exp) begin
            failures++;
            $display("FAIL reset_state cyc=%0d got=%h exp=%h", chk_from, obs[chk_from], rst_exp);
        end
        for (int c = chk_from; c < cyc; c++) begin
            checks++;
            if (obs[c] !== expv(c)) begin
                failures++;
                $display("FAIL reset_seq cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
            end
        end
    endtask

    task automatic test_contiguous();
        logic [W-1:0] beats[4];
        int c0, ta, n_out, first_out;
        beats[0] = 32'h04030201; beats[1] = 32'h08070605;
        beats[2] = 32'h0C0B0A09; beats[3] = 32'h100F0E0D;
        c0 = cyc;
        ta = cyc + 3;
        for (int i = 0; i < 4; i++) cycle(1'b1, beats[i], 1'b0, 1'b0);
        idle(18);
        n_out = 0; first_out = -1;
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (obs[c] !== expv(c)) begin
                failures++;
                $display("FAIL contiguous cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
            end
            if (obs[c][3] === 1'b1) begin
                n_out++;
                if (first_out < 0) first_out = c;
            end
        end
        checks++;
        if (n_out != DL || first_out != ta + 2) begin
            failures++;
            $display("FAIL contiguous_out_en count=%0d first=%0d exp_count=%0d exp_first=%0d", n_out, first_out, DL, ta + 2);
        end
        checks++;
        if ({obs[ta + 15][2], obs[ta + 15][1], obs[ta + 15][3], obs[ta + 15][37], obs[ta + 16][37]} !== 5'b11001) begin
            failures++;
            $display("FAIL contiguous_end got=%b exp=11001",
                     {obs[ta + 15][2], obs[ta + 15][1], obs[ta + 15][3], obs[ta + 15][37], obs[ta + 16][37]});
        end
    endtask

    task automatic test_gaps();
        logic pattern[7];
        int c0;
        pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        c0 = cyc;
        for (int i = 0; i < 7; i++) cycle(pattern[i], W'($urandom), 1'b0, 1'b0);
        idle(18);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (obs[c] !== expv(c)) begin
                failures++;
                $display("FAIL gaps cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
            end
        end
    endtask

    task automatic test_flush_drain();
        int c0, ta, f;
        c0 = cyc;
        for (int i = 0; i < 4; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        ta = cyc - 1;
        f = ta + 1 + int'($urandom_range(0, DL));
        idle(f - cyc);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(6);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (obs[c] !== expv(c)) begin
                failures++;
                $display("FAIL flush_drain cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
            end
        end
        checks++;
        if ({obs[f + 1][3], obs[f + 2][2], obs[f + 2][1], obs[f + 2][37], obs[f + 3][37]} !== 5'b01001) begin
            failures++;
            $display("FAIL flush_drain_seq flush_at=%0d got=%b exp=01001", f,
                     {obs[f + 1][3], obs[f + 2][2], obs[f + 2][1], obs[f + 2][37], obs[f + 3][37]});
        end
    endtask

    task automatic test_flush_load();
        int c0;
        c0 = cyc;
        cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        cycle(1'b1, W'($urandom), 1'b1, 1'b0);
        cycle(1'b1, W'($urandom), 1'b1, 1'b0);
        cycle(1'b1, W'($urandom), 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        idle(DL + 1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(4);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (obs[c] !== expv(c)) begin
                failures++;
                $display("FAIL flush_load cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [OW-1:0] rst_exp;
        int c0, cr;
        rst_exp = {1'b1, {(OW - 1){1'b0}}};
        c0 = cyc;
        cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        cr = cyc;
        cycle(1'b1, W'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        idle(18);
        checks++;
        if (obs[cr + 1] !== rst_exp) begin
            failures++;
            $display("FAIL rst_mid_state cyc=%0d got=%h exp=%h", cr + 1, obs[cr + 1], rst_exp);
        end
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (obs[c] !== expv(c)) begin
                failures++;
                $display("FAIL rst_mid cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0, split, gap, n1, n2;
        int lq[$];
        c0 = cyc;
        repeat (23) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        idle(18);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (obs[c] !== expv(c)) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
            end
            if (obs[c][36] === 1'b1) lq.push_back(c);
        end
        gap = (lq.size() >= 5) ? lq[4] - lq[3] : -1;
        split = (lq.size() >= 5) ? lq[4] : cyc;
        n1 = 0; n2 = 0;
        for (int c = c0; c < cyc; c++) begin
            if (obs[c][3] === 1'b1) begin
                if (c < split) n1++;
                else n2++;
            end
        end
        checks++;
        if (lq.size() != 8 || gap != 16) begin
            failures++;
            $display("FAIL back_to_back_accepts loads=%0d gap=%0d exp_loads=8 exp_gap=16", lq.size(), gap);
        end
        checks++;
        if (n1 != DL || n2 != DL) begin
            failures++;
            $display("FAIL back_to_back_out_en tile1=%0d tile2=%0d exp=%0d", n1, n2, DL);
        end
    endtask

    task automatic test_random();
        int c0;
        logic v, fl, r;
        c0 = cyc;
        repeat (300) begin
            v  = ($urandom_range(0, 99) < 70);
            fl = ($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 99) < 1);
            cycle(v, W'($urandom), fl, r);
        end
        idle(DL + 4);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (obs[c] !== expv(c)) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            e_load[k] = 0; e_out[k] = 0; e_dc[k] = 0; e_done[k] = 0;
            e_ready[k] = 0; e_busy[k] = 0; e_data[k] = '0; obs[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_contiguous();
        test_gaps();
        test_flush_drain();
        test_flush_load();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
